// File: rtl/des_bridge_pkg.sv
// Shared types and sizing helpers for the DES serial pad bridge.
// DES_BRIDGE_CHECK_PARAMS rejects bus widths that do not evenly split the block and key.
package des_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      UNLOAD
   } state_t;

   function automatic int text_beats(input int block_w, input int bus_w);
      return block_w / bus_w;
   endfunction

   function automatic int key_beats(input int key_w, input int bus_w);
      return key_w / bus_w;
   endfunction

   function automatic int result_beats(input int block_w, input int bus_w);
      return block_w / bus_w;
   endfunction

   function automatic int cnt_width(input int tb, input int kb);
      return $clog2(tb + kb + 1);
   endfunction

endpackage

`define DES_BRIDGE_CHECK_PARAMS(BUS, BLK, KEY) \
   if ((((BLK) % (BUS)) != 0) || (((KEY) % (BUS)) != 0)) begin : g_param_check \
      $error("des_serial_bridge: BUS_W must divide BLOCK_W and KEY_W"); \
   end

// File: rtl/des_serial_bridge_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pad level.
// It produces the synchronised level and a one-cycle rising-edge pulse.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic level,
   output logic rise
);

   if (SYNC_STAGES < 2) begin : g_stage_check
      $error("sync_edge: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;

endmodule

// File: rtl/des_serial_bridge.sv
// Handshaked byte/word-serial front end for the DES core: loads text+key, starts the core, streams the result.
// Build option DES_BRIDGE_TIMEOUT_EN adds an idle timeout that aborts partial frames.
module des_serial_bridge
   import des_bridge_pkg::*;
#(
   parameter int BUS_W       = 8,
   parameter int BLOCK_W     = 64,
   parameter int KEY_W       = 64,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               rx_req,
   input  logic [BUS_W-1:0]   rx_data,
   input  logic               rx_mode,
   output logic               rx_ack,
   output logic [BUS_W-1:0]   tx_data,
   output logic               tx_valid,
   input  logic               tx_ack,
   output logic [BLOCK_W-1:0] core_text,
   output logic [KEY_W-1:0]   core_key,
   output logic               core_start,
   output logic               core_encrypt,
   input  logic               core_dv,
   input  logic [BLOCK_W-1:0] core_result,
   output logic               busy,
   output logic               err_timeout
);

   `DES_BRIDGE_CHECK_PARAMS(BUS_W, BLOCK_W, KEY_W)

   if (TIMEOUT_CYC < 1) begin : g_timeout_check
      $error("des_serial_bridge: TIMEOUT_CYC must be at least 1");
   end

   localparam int TB = text_beats(BLOCK_W, BUS_W);
   localparam int KB = key_beats(KEY_W, BUS_W);
   localparam int RB = result_beats(BLOCK_W, BUS_W);
   localparam int CW = cnt_width(TB, KB);
   localparam logic [CW-1:0] LAST_SLOT = CW'(TB + KB - 1);
   localparam logic [CW-1:0] LAST_TX   = CW'(RB - 1);

   state_t             state, state_next;
   logic [CW-1:0]      cnt;
   logic [BLOCK_W-1:0] text_q;
   logic [KEY_W-1:0]   key_q;
   logic [BLOCK_W-1:0] result_q;
   logic               encrypt_q;
   logic               rx_level, rx_rise;
   logic               tx_rise, tx_level_unused;
   logic               loading, abort;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (rx_req),
      .level    (rx_level),
      .rise     (rx_rise)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tx_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (tx_ack),
      .level    (tx_level_unused),
      .rise     (tx_rise)
   );

   assign loading = (state == IDLE) || (state == LOAD);

`ifdef DES_BRIDGE_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT_CYC + 1);

   logic [IW-1:0] idle_cnt;
   logic          err_q;

   assign abort = (state == LOAD) && !rx_rise && (idle_cnt == IW'(TIMEOUT_CYC - 1));

   // Idle cycles since the last accepted beat; the error flag is cleared by the next accepted beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= '0;
         err_q    <= 1'b0;
      end else if (loading && rx_rise) begin
         idle_cnt <= '0;
         err_q    <= 1'b0;
      end else if (abort) begin
         idle_cnt <= '0;
         err_q    <= 1'b1;
      end else if (state == LOAD) begin
         idle_cnt <= idle_cnt + IW'(1);
      end else begin
         idle_cnt <= '0;
      end
   end

   assign err_timeout = err_q;
`else
   assign abort       = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      core_start = 1'b0;
      case (state)
         IDLE: begin
            if (rx_rise) state_next = (cnt == LAST_SLOT) ? START : LOAD;
         end
         LOAD: begin
            if (rx_rise)    state_next = (cnt == LAST_SLOT) ? START : LOAD;
            else if (abort) state_next = IDLE;
         end
         START: begin
            core_start = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (core_dv) state_next = UNLOAD;
         end
         UNLOAD: begin
            if (tx_rise && (cnt == LAST_TX)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // One counter serves as the rx slot index while loading and the tx beat index while unloading.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         text_q    <= '0;
         key_q     <= '0;
         result_q  <= '0;
         encrypt_q <= 1'b0;
      end else begin
         case (state)
            IDLE, LOAD: begin
               if (rx_rise) begin
                  for (int i = 0; i < TB; i++) begin
                     if (cnt == CW'(i)) text_q[i*BUS_W +: BUS_W] <= rx_data;
                  end
                  for (int i = 0; i < KB; i++) begin
                     if (cnt == CW'(TB + i)) key_q[i*BUS_W +: BUS_W] <= rx_data;
                  end
                  if (cnt == LAST_SLOT) begin
                     cnt       <= '0;
                     encrypt_q <= rx_mode;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end else if (abort) begin
                  cnt <= '0;
               end
            end
            WAIT: begin
               if (core_dv) begin
                  result_q <= core_result;
                  cnt      <= '0;
               end
            end
            UNLOAD: begin
               if (tx_rise) begin
                  result_q <= result_q >> BUS_W;
                  cnt      <= (cnt == LAST_TX) ? '0 : cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign rx_ack       = rx_level & loading;
   assign tx_data      = result_q[BUS_W-1:0];
   assign tx_valid     = (state == UNLOAD);
   assign busy         = (state != IDLE);
   assign core_text    = text_q;
   assign core_key     = key_q;
   assign core_encrypt = encrypt_q;

endmodule

// File: tb/tb_des_serial_bridge.sv
// Directed self-checking bench for des_serial_bridge: byte-wide instance plus a 32-bit-wide instance.
// The timeout section follows DES_BRIDGE_TIMEOUT_EN when that macro is defined for the build.
module tb_des_serial_bridge;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic        rx_req, rx_mode, rx_ack, tx_valid, tx_ack;
   logic [7:0]  rx_data, tx_data;
   logic [63:0] core_text, core_key, core_result;
   logic        core_start, core_encrypt, core_dv, busy, err_timeout;

   logic        w_rx_req, w_rx_mode, w_rx_ack, w_tx_valid, w_tx_ack;
   logic [31:0] w_rx_data, w_tx_data;
   logic [63:0] w_core_text, w_core_key, w_core_result;
   logic        w_core_start, w_core_encrypt, w_core_dv, w_busy, w_err_timeout;

   int errors = 0;
   int checks = 0;
   int starts = 0;
   int w_starts = 0;

   des_serial_bridge #(
      .BUS_W(8), .BLOCK_W(64), .KEY_W(64), .SYNC_STAGES(2), .TIMEOUT_CYC(32)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .rx_req(rx_req), .rx_data(rx_data), .rx_mode(rx_mode), .rx_ack(rx_ack),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
      .core_text(core_text), .core_key(core_key), .core_start(core_start),
      .core_encrypt(core_encrypt), .core_dv(core_dv), .core_result(core_result),
      .busy(busy), .err_timeout(err_timeout)
   );

   des_serial_bridge #(
      .BUS_W(32), .BLOCK_W(64), .KEY_W(64), .SYNC_STAGES(2), .TIMEOUT_CYC(32)
   ) dut_wide (
      .clk(clk), .reset_n(reset_n),
      .rx_req(w_rx_req), .rx_data(w_rx_data), .rx_mode(w_rx_mode), .rx_ack(w_rx_ack),
      .tx_data(w_tx_data), .tx_valid(w_tx_valid), .tx_ack(w_tx_ack),
      .core_text(w_core_text), .core_key(w_core_key), .core_start(w_core_start),
      .core_encrypt(w_core_encrypt), .core_dv(w_core_dv), .core_result(w_core_result),
      .busy(w_busy), .err_timeout(w_err_timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (core_start === 1'b1)   starts++;
      if (w_core_start === 1'b1) w_starts++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic mode);
      int t;
      rx_data = data;
      rx_mode = mode;
      rx_req  = 1'b1;
      t = 0;
      while (rx_ack !== 1'b1 && t < 40) begin tick(1); t++; end
      if (rx_ack !== 1'b1) checkOutput("rx_ack_high_wait", {63'd0, rx_ack}, 64'd1);
      rx_req = 1'b0;
      t = 0;
      while (rx_ack !== 1'b0 && t < 40) begin tick(1); t++; end
      if (rx_ack !== 1'b0) checkOutput("rx_ack_low_wait", {63'd0, rx_ack}, 64'd0);
      tick(1);
   endtask

   task automatic applyWide(input logic [31:0] data, input logic mode);
      int t;
      w_rx_data = data;
      w_rx_mode = mode;
      w_rx_req  = 1'b1;
      t = 0;
      while (w_rx_ack !== 1'b1 && t < 40) begin tick(1); t++; end
      if (w_rx_ack !== 1'b1) checkOutput("w_rx_ack_high_wait", {63'd0, w_rx_ack}, 64'd1);
      w_rx_req = 1'b0;
      t = 0;
      while (w_rx_ack !== 1'b0 && t < 40) begin tick(1); t++; end
      if (w_rx_ack !== 1'b0) checkOutput("w_rx_ack_low_wait", {63'd0, w_rx_ack}, 64'd0);
      tick(1);
   endtask

   task automatic sendFrame(input logic [7:0] base, input logic mode);
      for (int i = 0; i < 16; i++) applyStimulus(base + 8'(i), (i == 15) ? mode : 1'b0);
      tick(3);
   endtask

   task automatic pulseDv(input logic [63:0] res);
      core_result = res;
      core_dv     = 1'b1;
      tick(1);
      core_dv     = 1'b0;
   endtask

   task automatic ackTx();
      tx_ack = 1'b1;
      tick(6);
      tx_ack = 1'b0;
      tick(6);
   endtask

   task automatic ackWide();
      w_tx_ack = 1'b1;
      tick(6);
      w_tx_ack = 1'b0;
      tick(6);
   endtask

   task automatic unloadAll(input logic [63:0] res, input string tag);
      for (int j = 0; j < 8; j++) begin
         checkOutput($sformatf("%s_tx_valid%0d", tag, j), {63'd0, tx_valid}, 64'd1);
         checkOutput($sformatf("%s_tx_data%0d", tag, j), {56'd0, tx_data}, {56'd0, res[8*j +: 8]});
         ackTx();
      end
      checkOutput({tag, "_tx_valid_done"}, {63'd0, tx_valid}, 64'd0);
      checkOutput({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      rx_req = 1'b0; rx_data = '0; rx_mode = 1'b0; tx_ack = 1'b0;
      core_dv = 1'b0; core_result = '0;
      w_rx_req = 1'b0; w_rx_data = '0; w_rx_mode = 1'b0; w_tx_ack = 1'b0;
      w_core_dv = 1'b0; w_core_result = '0;
      reset_n = 1'b0;
      tick(3);

      checkOutput("rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("rst_rx_ack", {63'd0, rx_ack}, 64'd0);
      checkOutput("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
      checkOutput("rst_tx_data", {56'd0, tx_data}, 64'd0);
      checkOutput("rst_text", core_text, 64'd0);
      checkOutput("rst_key", core_key, 64'd0);
      checkOutput("rst_start", {63'd0, core_start}, 64'd0);
      checkOutput("rst_encrypt", {63'd0, core_encrypt}, 64'd0);
      checkOutput("rst_err", {63'd0, err_timeout}, 64'd0);
      reset_n = 1'b1;
      tick(2);

      sendFrame(8'h00, 1'b1);
      checkOutput("f1_text", core_text, 64'h0706050403020100);
      checkOutput("f1_key", core_key, 64'h0F0E0D0C0B0A0908);
      checkOutput("f1_encrypt", {63'd0, core_encrypt}, 64'd1);
      checkOutput("f1_starts", 64'(starts), 64'd1);
      checkOutput("f1_busy", {63'd0, busy}, 64'd1);

      rx_data = 8'hEE;
      rx_req  = 1'b1;
      tick(8);
      checkOutput("bp_rx_ack", {63'd0, rx_ack}, 64'd0);
      rx_req = 1'b0;
      tick(6);
      checkOutput("bp_text", core_text, 64'h0706050403020100);
      checkOutput("bp_key", core_key, 64'h0F0E0D0C0B0A0908);
      checkOutput("bp_tx_valid", {63'd0, tx_valid}, 64'd0);

      pulseDv(64'h8877665544332211);
      unloadAll(64'h8877665544332211, "u1");
      checkOutput("u1_starts", 64'(starts), 64'd1);

      sendFrame(8'hA0, 1'b0);
      checkOutput("f2_text", core_text, 64'hA7A6A5A4A3A2A1A0);
      checkOutput("f2_key", core_key, 64'hAFAEADACABAAA9A8);
      checkOutput("f2_encrypt", {63'd0, core_encrypt}, 64'd0);
      checkOutput("f2_starts", 64'(starts), 64'd2);

      pulseDv(64'h0123456789ABCDEF);
      checkOutput("f2_tx0", {56'd0, tx_data}, 64'hEF);
      ackTx();
      checkOutput("f2_tx1", {56'd0, tx_data}, 64'hCD);
      ackTx();
      reset_n = 1'b0;
      #1;
      checkOutput("rstu_tx_valid", {63'd0, tx_valid}, 64'd0);
      checkOutput("rstu_tx_data", {56'd0, tx_data}, 64'd0);
      checkOutput("rstu_busy", {63'd0, busy}, 64'd0);
      checkOutput("rstu_text", core_text, 64'd0);
      checkOutput("rstu_key", core_key, 64'd0);
      tick(2);
      reset_n = 1'b1;
      tick(2);

      for (int i = 0; i < 5; i++) applyStimulus(8'h50 + 8'(i), 1'b0);
      checkOutput("rstl_busy_before", {63'd0, busy}, 64'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("rstl_busy", {63'd0, busy}, 64'd0);
      checkOutput("rstl_text", core_text, 64'd0);
      checkOutput("rstl_rx_ack", {63'd0, rx_ack}, 64'd0);
      tick(2);
      reset_n = 1'b1;
      tick(4);
      checkOutput("rstl_starts", 64'(starts), 64'd2);

      sendFrame(8'h30, 1'b1);
      checkOutput("f3_text", core_text, 64'h3736353433323130);
      checkOutput("f3_key", core_key, 64'h3F3E3D3C3B3A3938);
      checkOutput("f3_encrypt", {63'd0, core_encrypt}, 64'd1);
      checkOutput("f3_starts", 64'(starts), 64'd3);
      pulseDv(64'hFEDCBA9876543210);
      unloadAll(64'hFEDCBA9876543210, "u3");

      for (int i = 0; i < 3; i++) applyStimulus(8'hC0 + 8'(i), 1'b0);
      tick(40);
`ifdef DES_BRIDGE_TIMEOUT_EN
      checkOutput("to_busy", {63'd0, busy}, 64'd0);
      checkOutput("to_err", {63'd0, err_timeout}, 64'd1);
      applyStimulus(8'h5A, 1'b0);
      checkOutput("to_err_clear", {63'd0, err_timeout}, 64'd0);
      checkOutput("to_slot0", {56'd0, core_text[7:0]}, 64'h5A);
      checkOutput("to_busy_reload", {63'd0, busy}, 64'd1);
`else
      checkOutput("nto_busy", {63'd0, busy}, 64'd1);
      checkOutput("nto_err", {63'd0, err_timeout}, 64'd0);
      checkOutput("nto_partial", {40'd0, core_text[23:0]}, 64'hC2C1C0);
`endif
      checkOutput("to_starts", 64'(starts), 64'd3);
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(2);

      for (int i = 0; i < 4; i++) applyWide(32'h1000_0000 + 32'(i), (i == 3));
      tick(3);
      checkOutput("w_text", w_core_text, 64'h1000000110000000);
      checkOutput("w_key", w_core_key, 64'h1000000310000002);
      checkOutput("w_encrypt", {63'd0, w_core_encrypt}, 64'd1);
      checkOutput("w_starts", 64'(w_starts), 64'd1);
      w_core_result = 64'h8877665544332211;
      w_core_dv = 1'b1;
      tick(1);
      w_core_dv = 1'b0;
      checkOutput("w_tx0", {32'd0, w_tx_data}, 64'h44332211);
      ackWide();
      checkOutput("w_tx1", {32'd0, w_tx_data}, 64'h88776655);
      checkOutput("w_tx_valid1", {63'd0, w_tx_valid}, 64'd1);
      ackWide();
      checkOutput("w_tx_valid_done", {63'd0, w_tx_valid}, 64'd0);
      checkOutput("w_busy_done", {63'd0, w_busy}, 64'd0);
      checkOutput("main_starts_final", 64'(starts), 64'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
